fc_layer_ctrl: RTL and testbench
================================

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter M, default 8: input vector length (number of MACs per output); SHALL be >= 2.
REQ-002 Parameter N, default 8: output vector length (number of rows); SHALL be >= 2.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port s_valid, input, 1: upstream input word valid.
REQ-006 Port s_ready, output, 1: controller accepts an input word.
REQ-007 Port m_valid, output, 1: accumulator result ready for downstream.
REQ-008 Port m_ready, input, 1: downstream accepts the result.
REQ-009 Port wr_en_x, output, 1: input-memory write enable.
REQ-010 Port addr_x, output, $clog2(M): input-memory address, used for both write and read.
REQ-011 Port addr_w, output, $clog2(M*N): weight-ROM read address.
REQ-012 Port clear_acc, output, 1: zero the accumulator.
REQ-013 Port en_acc, output, 1: accumulate the current product.
REQ-014 Port out_idx, output, $clog2(N): index of the row being computed or presented.
REQ-015 Port busy, output, 1: high in every state except S_LOAD.
REQ-016 Port layer_done, output, 1: one-cycle pulse on acceptance of the final output.

Function
REQ-017 FSM states SHALL be S_LOAD, S_CLEAR, S_MAC, S_DRAIN and S_OUT; counters SHALL be load/MAC index k (0..M-1) and row r (0..N-1).
REQ-018 S_LOAD: s_ready=1; wr_en_x=s_valid (combinational); addr_x=k; each accept (s_valid&&s_ready) increments k.
REQ-019 S_LOAD: an accept with k==M-1 SHALL clear k and go to S_CLEAR; s_valid without s_ready SHALL have no effect.
REQ-020 S_CLEAR: clear_acc=1 for exactly one cycle; s_ready=0; next state S_MAC.
REQ-021 S_MAC: addr_x=k and addr_w=r*M+k, with addr_w generated by a running counter (no multiplier); k increments every cycle; k==M-1 goes to S_DRAIN.
REQ-022 Memories have 1-cycle read latency, so en_acc SHALL be high in the cycle after each S_MAC cycle (S_MAC k=1..M-1 plus S_DRAIN), exactly M cycles per row.
REQ-023 S_DRAIN: en_acc=1 for one cycle; next state S_OUT.
REQ-024 S_OUT: m_valid=1 and out_idx=r held stable until m_ready; the FSM SHALL NOT advance while m_ready=0.
REQ-025 S_OUT with m_ready and r<N-1: r++, then S_CLEAR.
REQ-026 S_OUT with m_ready and r==N-1: r=0, layer_done=1 for that cycle, then S_LOAD with s_ready=1 in the next cycle.
REQ-027 Latency: m_valid SHALL rise in the cycle after the (M+2)th edge following the edge that accepts the last input.
REQ-028 With m_ready=1, row-to-row period SHALL be M+3 cycles.
REQ-029 s_ready and m_valid SHALL never be high together; wr_en_x SHALL be 0 outside S_LOAD; clear_acc and en_acc SHALL be 0 in S_LOAD and S_OUT.
REQ-030 out_idx SHALL equal r in all states (0 in S_LOAD); addr_x and addr_w SHALL be 0 whenever they are unused.

Reset
REQ-031 reset=1 at an edge SHALL force S_LOAD, k=0, r=0 and the en_acc delay register=0 from any state, including mid-row and mid-load; partial data SHALL be discarded.
REQ-032 While reset is high, s_ready, m_valid, wr_en_x, clear_acc, en_acc, layer_done and busy SHALL be 0 and addr_x, addr_w, out_idx SHALL be 0.
REQ-033 In the first cycle after reset deasserts, s_ready SHALL be 1.

Verification
REQ-034 M=N=8, reset, then 8 back-to-back s_valid -> wr_en_x with addr_x 0..7; s_ready=0 from the cycle after the 8th accept; busy=1.
REQ-035 Row 0 -> clear_acc 1 cycle, addr_w 0..7; row 3 -> addr_w 24..31; en_acc exactly 8 cycles per row, lagging the addresses by 1 cycle.
REQ-036 m_ready held 0 for 5 cycles in S_OUT, row 2 -> m_valid stays 1, out_idx=2, no address activity; row 3 starts the cycle after m_ready=1.
REQ-037 m_ready tied 1 -> first m_valid 10 cycles after the last accept; 8 outputs spaced 11 cycles apart; layer_done pulses with the 8th accept; s_ready=1 next cycle; a second vector processes identically.
REQ-038 reset pulsed during S_MAC row 5 -> all outputs 0 during reset; s_ready=1 after; a full new layer completes with out_idx 0..7.
REQ-039 Random s_valid/m_ready gaps over 100 layers -> exactly 8 accepts and 8 outputs per layer; REQ-029 invariants hold every cycle.

Source files
------------

// File: rtl/fc_layer_ctrl_if.sv
// Handshake and memory-control bundle between the FC-layer controller and its datapath.
// "master" is the controller side; "slave" is the upstream/downstream/datapath side.
interface fc_layer_ctrl_if #(
  parameter int M = 8,
  parameter int N = 8
);
  localparam int KW = $clog2(M);
  localparam int WW = $clog2(M * N);
  localparam int RW = $clog2(N);

  logic          s_valid;
  logic          s_ready;
  logic          m_valid;
  logic          m_ready;
  logic          wr_en_x;
  logic [KW-1:0] addr_x;
  logic [WW-1:0] addr_w;
  logic          clear_acc;
  logic          en_acc;
  logic [RW-1:0] out_idx;
  logic          busy;
  logic          layer_done;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, wr_en_x, addr_x, addr_w,
           clear_acc, en_acc, out_idx, busy, layer_done
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, wr_en_x, addr_x, addr_w,
           clear_acc, en_acc, out_idx, busy, layer_done
  );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer: loads an M-word input vector, then runs N rows of
// M multiply-accumulates against a weight ROM and hands each row result downstream.
module fc_layer_ctrl #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            reset,
  fc_layer_ctrl_if.master bus
);
  localparam int KW = $clog2(M);
  localparam int WW = $clog2(M * N);
  localparam int RW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);

  typedef enum logic [2:0] {S_LOAD, S_CLEAR, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic [RW-1:0] r_q;
  logic [WW-1:0] w_q;
  logic          en_acc_q;
  logic          run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      k_q      <= '0;
      r_q      <= '0;
      w_q      <= '0;
      en_acc_q <= 1'b0;
    end else begin
      // Memory reads land one cycle after their address, so accumulate one cycle late.
      en_acc_q <= (state_q == S_MAC);
      unique case (state_q)
        S_LOAD: begin
          if (bus.s_valid) begin
            if (k_q == K_LAST) begin
              k_q     <= '0;
              state_q <= S_CLEAR;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        S_CLEAR: state_q <= S_MAC;
        S_MAC: begin
          w_q <= w_q + WW'(1);
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= S_DRAIN;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_DRAIN: state_q <= S_OUT;
        S_OUT: begin
          if (bus.m_ready) begin
            if (r_q == R_LAST) begin
              r_q     <= '0;
              w_q     <= '0;
              state_q <= S_LOAD;
            end else begin
              r_q     <= r_q + RW'(1);
              state_q <= S_CLEAR;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Every output is forced low while reset is held, independent of the stale state.
  assign run            = !reset;
  assign bus.s_ready    = run && (state_q == S_LOAD);
  assign bus.wr_en_x    = bus.s_ready && bus.s_valid;
  assign bus.m_valid    = run && (state_q == S_OUT);
  assign bus.clear_acc  = run && (state_q == S_CLEAR);
  assign bus.en_acc     = run && en_acc_q;
  assign bus.busy       = run && (state_q != S_LOAD);
  assign bus.layer_done = bus.m_valid && bus.m_ready && (r_q == R_LAST);
  assign bus.addr_x     = (run && (state_q == S_LOAD || state_q == S_MAC)) ? k_q : '0;
  assign bus.addr_w     = (run && state_q == S_MAC) ? w_q : '0;
  assign bus.out_idx    = run ? r_q : '0;
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Scoreboard bench for fc_layer_ctrl: stimulus queues expected writes/rows, a negedge
// monitor checks every write, MAC sequence, output handshake and the per-cycle invariants.
module tb_fc_layer_ctrl;
  localparam int M = 8;
  localparam int N = 8;

  typedef struct {
    int idx;
    bit last;
  } out_t;

  logic clk = 1'b0;
  logic reset;

  fc_layer_ctrl_if #(.M(M), .N(N)) bus ();

  fc_layer_ctrl #(.M(M), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   exp_wr[$];
  out_t exp_out[$];

  int   c = 0;
  int   row_idx = 0;
  int   wr_addr;
  out_t cur;
  bit   exp_clear_next = 0;
  bit   exp_load_next = 0;
  bit   prev_reset = 0;
  bit   prev_stall = 0;
  int   layers_seen = 0;
  logic [9:0] rst_bits;

  int remaining = 0;
  bit force_sv = 0;
  bit rand_sv = 0;
  int mr_mode = 0;
  int stall_cnt = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: all DUT outputs sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      rst_bits = {bus.s_ready, bus.m_valid, bus.wr_en_x, bus.clear_acc, bus.en_acc,
                  bus.layer_done, bus.busy, |bus.addr_x, |bus.addr_w, |bus.out_idx};
      check("reset_outputs", int'(rst_bits), 0);
      exp_wr.delete();
      exp_out.delete();
      c = 0;
      exp_clear_next = 0;
      exp_load_next = 0;
      prev_stall = 0;
      prev_reset = 1;
    end else begin
      if (prev_reset) check("ready_after_reset", bus.s_ready, 1);
      prev_reset = 0;

      check("ready_and_valid", bus.s_ready && bus.m_valid, 0);
      check("wr_outside_load", bus.wr_en_x && !bus.s_ready, 0);
      check("acc_in_load_out", (bus.clear_acc || bus.en_acc) && (bus.s_ready || bus.m_valid), 0);
      check("busy_vs_ready", bus.busy, !bus.s_ready);
      check("layer_done_gate", bus.layer_done && !(bus.m_valid && bus.m_ready), 0);

      if (exp_clear_next) begin
        check("clear_follows", bus.clear_acc, 1);
        exp_clear_next = 0;
      end
      if (exp_load_next) begin
        check("load_after_done", int'({bus.s_ready, bus.busy, |bus.out_idx}), 3'b100);
        exp_load_next = 0;
      end
      if (prev_stall) check("valid_held", bus.m_valid, 1);

      if (bus.wr_en_x) begin
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          wr_addr = exp_wr.pop_front();
          check("addr_x_write", bus.addr_x, wr_addr);
          if (wr_addr == M - 1) exp_clear_next = 1;
        end
      end

      if (bus.clear_acc) begin
        check("clear_not_midrow", c, 0);
        check("en_acc_in_clear", bus.en_acc, 0);
        check("row_expected", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) row_idx = exp_out[0].idx;
        c = 1;
      end else if (c >= 1 && c <= M) begin
        check("addr_w_mac", bus.addr_w, row_idx * M + c - 1);
        check("addr_x_mac", bus.addr_x, c - 1);
        check("en_acc_mac", bus.en_acc, c >= 2);
        check("out_idx_mac", bus.out_idx, row_idx);
        c++;
      end else if (c == M + 1) begin
        check("drain", int'({bus.en_acc, bus.m_valid, |bus.addr_w}), 3'b100);
        c++;
      end else if (c == M + 2) begin
        check("m_valid_latency", bus.m_valid, 1);
        c = 0;
      end

      prev_stall = 0;
      if (bus.m_valid) begin
        check("output_expected", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) begin
          check("out_idx_out", bus.out_idx, exp_out[0].idx);
          check("no_addr_in_out", int'({|bus.addr_x, |bus.addr_w}), 0);
          if (bus.m_ready) begin
            cur = exp_out.pop_front();
            check("layer_done", bus.layer_done, cur.last);
            if (cur.last) begin
              exp_load_next = 1;
              layers_seen++;
              $display("layer %0d complete at %0t", layers_seen, $time);
            end else begin
              exp_clear_next = 1;
            end
          end else begin
            prev_stall = 1;
          end
        end
      end
    end
  end

  // Upstream driver: offers words until the requested number has been accepted.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (force_sv) bus.s_valid = 1'b1;
      else if (remaining > 0) bus.s_valid = rand_sv ? ($urandom_range(0, 3) != 0) : 1'b1;
      else bus.s_valid = 1'b0;
      if (bus.s_valid && bus.s_ready && remaining > 0) remaining--;
    end
  end

  // Downstream driver.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (mr_mode)
        0: bus.m_ready = 1'b1;
        1: bus.m_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.m_valid && bus.out_idx == 2 && stall_cnt < 5) begin
            bus.m_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.m_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic push_layer();
    out_t o;
    for (int i = 0; i < M; i++) exp_wr.push_back(i);
    for (int r = 0; r < N; r++) begin
      o.idx = r;
      o.last = (r == N - 1);
      exp_out.push_back(o);
    end
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    reset = 1'b1;
    force_sv = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    force_sv = 0;

    // Two back-to-back layers, downstream always ready.
    mr_mode = 0;
    push_layer();
    push_layer();
    remaining = 2 * M;
    wait_drain(2000);

    // Downstream stalls row 2 for five cycles.
    mr_mode = 2;
    stall_cnt = 0;
    push_layer();
    remaining = M;
    wait_drain(2000);
    check("stall_applied", stall_cnt, 5);

    // Reset in the middle of row 5, then a clean layer.
    mr_mode = 0;
    push_layer();
    remaining = M;
    n = 0;
    while (!(bus.out_idx == 5 && bus.en_acc) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_row5", n < 1000, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    remaining = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push_layer();
    remaining = M;
    wait_drain(2000);

    // 100 layers with random gaps on both sides.
    mr_mode = 1;
    rand_sv = 1;
    for (int l = 0; l < 100; l++) push_layer();
    remaining = 100 * M;
    wait_drain(40000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
